// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter placed directly in front of the write side of a
// synchronous FIFO. NUM_REQ producers each present beats with a valid/ready
// handshake. One producer at a time holds a grant for a burst of up to
// MAX_BURST beats. Beats are forwarded to the FIFO write port and are
// throttled by the FIFO full flag.
//
// Optional feature macro: FIFO_ARB_STATS_EN
//   defined   -> one saturating CNT_WIDTH transfer counter per producer,
//                readable through stat_sel / stat_cnt
//   undefined -> no counters, stat_cnt is tied to 0, stat_sel is ignored
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   req_valid    in   [NUM_REQ]             producer i has a beat
//   req_last     in   [NUM_REQ]             producer i's current beat ends its burst
//   req_data     in   [NUM_REQ*DATA_WIDTH]  producer i data in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    out  [NUM_REQ]             producer i beat accepted when valid & ready
//   fifo_full    in   FIFO full flag
//   fifo_wr_en   out  FIFO write strobe
//   fifo_wr_data out  [DATA_WIDTH]          FIFO write data (0 when not writing)
//   grant_id     out  [GW]                  index of the granted producer
//   busy         out  high while a grant is held
//   stat_sel     in   [GW]                  statistics counter select
//   stat_cnt     out  [CNT_WIDTH]           selected statistics counter
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    parameter  int CNT_WIDTH  = 16,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    input  logic [GW-1:0]                 stat_sel,
    output logic [CNT_WIDTH-1:0]          stat_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [GW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic            in_grant;
    logic            g_valid;
    logic            g_last;
    logic            xfer;
    logic            burst_done;
    logic            release_grant;
    logic [GW-1:0]   grant_next;

    // Split the flat producer data bus into one word per producer.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid producer at or above rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int            idx;
            logic [GW-1:0] cand;
            idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand = GW'(idx);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign in_grant   = (state_q == ST_GRANT);
    assign g_valid    = req_valid[grant_id_q];
    assign g_last     = req_last[grant_id_q];
    assign xfer       = in_grant && g_valid && !fifo_full;
    assign burst_done = (beat_cnt_q == BW'(MAX_BURST - 1));

    // Release on a last beat, on the beat that fills the burst, or when the
    // granted producer has nothing to send while the FIFO could accept it.
    // A valid drop while the FIFO is full keeps the grant.
    assign release_grant = (xfer && (g_last || burst_done))
                         || (in_grant && !g_valid && !fifo_full);

    assign grant_next = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
                if (release_grant) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Write-side outputs follow fifo_full combinationally so a full FIFO
    // never sees a write strobe.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (in_grant) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = xfer;
            if (xfer) begin
                fifo_wr_data = data_arr[grant_id_q];
            end
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = in_grant;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

    // Per-producer transfer counters, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (xfer && (cnt_q[grant_id_q] != '1)) begin
            cnt_d[grant_id_q] = cnt_q[grant_id_q] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        if (int'(stat_sel) < NUM_REQ) begin
            stat_cnt = cnt_q[stat_sel];
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge. With FIFO_ARB_STATS_EN defined the counters are built
// with CNT_WIDTH=4 so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_STATS_EN
    localparam int CNT_W     = 4;
    localparam int EXP_CNT10 = 10;
    localparam int EXP_CNT30 = 15;
`else
    localparam int CNT_W     = 16;
    localparam int EXP_CNT10 = 0;
    localparam int EXP_CNT30 = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_last;
    logic [31:0]      req_data;
    logic [3:0]       req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [7:0]       fifo_wr_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic [1:0]       stat_sel;
    logic [CNT_W-1:0] stat_cnt;

    int pass_cnt  = 0;
    int check_cnt = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .MAX_BURST (4),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .grant_id    (grant_id),
        .busy        (busy),
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt)
    );

    always #5 clk = ~clk;

    // Full-stall scenario tables, bit/byte c = cycle c.
    localparam logic [8:0]  FS_FULL  = 9'b000111000;
    localparam logic [8:0]  FS_VALID = 9'b011101111;
    localparam logic [8:0]  FS_WREN  = 9'b011000110;
    localparam logic [8:0]  FS_BUSY  = 9'b011111110;
    localparam logic [71:0] FS_DRV   = {8'h00, 8'h43, 8'h42, 8'h42, 8'h42, 8'h42, 8'h41, 8'h40, 8'h40};
    localparam logic [71:0] FS_EXP   = {8'h00, 8'h43, 8'h42, 8'h00, 8'h00, 8'h00, 8'h41, 8'h40, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        stat_sel  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_cnt++;
            if (req_ready !== 4'b0000) $display("FAIL reset_ready c%0d: got %b want 0000", c, req_ready);
            else pass_cnt++;
            check_cnt++;
            if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en c%0d: got %b want 0", c, fifo_wr_en);
            else pass_cnt++;
            check_cnt++;
            if (busy !== 1'b0) $display("FAIL reset_busy c%0d: got %b want 0", c, busy);
            else pass_cnt++;
            check_cnt++;
            if (grant_id !== 2'd0) $display("FAIL reset_grant c%0d: got %0d want 0", c, grant_id);
            else pass_cnt++;
            check_cnt++;
            if (stat_cnt !== '0) $display("FAIL reset_stat c%0d: got %0d want 0", c, stat_cnt);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        req_valid       = 4'b0010;
        req_data[15:8]  = 8'hA1;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL single_arb_cycle: busy=%b wr_en=%b ready=%b want 0 0 0000", busy, fifo_wr_en, req_ready);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (grant_id !== 2'd1) $display("FAIL single_grant: got %0d want 1", grant_id);
        else pass_cnt++;
        check_cnt++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hA1)
            $display("FAIL single_beat1: wr_en=%b data=%h want 1 a1", fifo_wr_en, fifo_wr_data);
        else pass_cnt++;
        check_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL single_ready: got %b want 0010", req_ready);
        else pass_cnt++;
        tick();
        req_data[15:8] = 8'hA2;
        req_last       = 4'b0010;
        @(negedge clk);
        check_cnt++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hA2)
            $display("FAIL single_beat2: wr_en=%b data=%h want 1 a2", fifo_wr_en, fifo_wr_data);
        else pass_cnt++;
        tick();
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0)
            $display("FAIL single_release: busy=%b wr_en=%b want 0 0", busy, fifo_wr_en);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        for (int c = 0; c < 25; c++) begin
            int phase;
            int g;
            phase = c % 5;
            g     = (c / 5) % 4;
            @(negedge clk);
            if (phase == 0) begin
                check_cnt++;
                if (busy !== 1'b0 || fifo_wr_en !== 1'b0)
                    $display("FAIL rr_idle c%0d: busy=%b wr_en=%b want 0 0", c, busy, fifo_wr_en);
                else pass_cnt++;
            end else begin
                check_cnt++;
                if (busy !== 1'b1 || grant_id !== 2'(g))
                    $display("FAIL rr_grant c%0d: busy=%b grant=%0d want 1 %0d", c, busy, grant_id, g);
                else pass_cnt++;
                check_cnt++;
                if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'(8'h10 + g))
                    $display("FAIL rr_beat c%0d: wr_en=%b data=%h want 1 %h", c, fifo_wr_en, fifo_wr_data, 8'(8'h10 + g));
                else pass_cnt++;
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            logic [7:0] exp_data;
            req_valid      = {3'b000, FS_VALID[c]};
            fifo_full      = FS_FULL[c];
            req_data[7:0]  = FS_DRV[c*8 +: 8];
            exp_data       = FS_EXP[c*8 +: 8];
            @(negedge clk);
            check_cnt++;
            if (fifo_wr_en !== FS_WREN[c])
                $display("FAIL full_wr_en c%0d: got %b want %b", c, fifo_wr_en, FS_WREN[c]);
            else pass_cnt++;
            check_cnt++;
            if (busy !== FS_BUSY[c])
                $display("FAIL full_busy c%0d: got %b want %b", c, busy, FS_BUSY[c]);
            else pass_cnt++;
            check_cnt++;
            if (fifo_wr_data !== exp_data)
                $display("FAIL full_data c%0d: got %h want %h", c, fifo_wr_data, exp_data);
            else pass_cnt++;
            check_cnt++;
            if (req_ready !== {3'b000, FS_WREN[c]})
                $display("FAIL full_ready c%0d: got %b want %b", c, req_ready, {3'b000, FS_WREN[c]});
            else pass_cnt++;
            tick();
        end
        fifo_full = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_valid_drop();
        do_reset();
        req_valid        = 4'b0100;
        req_data[23:16]  = 8'h52;
        tick();
        req_valid        = 4'b1101;
        req_data[7:0]    = 8'h50;
        req_data[31:24]  = 8'h53;
        req_last         = 4'b1001;
        @(negedge clk);
        check_cnt++;
        if (grant_id !== 2'd2 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h52)
            $display("FAIL drop_first: grant=%0d wr_en=%b data=%h want 2 1 52", grant_id, fifo_wr_en, fifo_wr_data);
        else pass_cnt++;
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b1 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0100)
            $display("FAIL drop_cycle: busy=%b wr_en=%b ready=%b want 1 0 0100", busy, fifo_wr_en, req_ready);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL drop_release: busy=%b want 0", busy);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (grant_id !== 2'd3 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h53)
            $display("FAIL drop_next3: grant=%0d wr_en=%b data=%h want 3 1 53", grant_id, fifo_wr_en, fifo_wr_data);
        else pass_cnt++;
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL drop_gap: busy=%b want 0", busy);
        else pass_cnt++;
        tick();
        @(negedge clk);
        check_cnt++;
        if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h50)
            $display("FAIL drop_next0: grant=%0d wr_en=%b data=%h want 0 1 50", grant_id, fifo_wr_en, fifo_wr_data);
        else pass_cnt++;
        tick();
        req_valid = '0;
        req_last  = '0;
        tick();
    endtask

    // Drive producer 2 until total_writes beats have been accepted.
    task automatic run_beats(input int target, inout int writes, output bit timed_out);
        timed_out = 1'b1;
        req_valid = 4'b0100;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (fifo_wr_en === 1'b1) writes++;
            tick();
            if (writes >= target) begin
                timed_out = 1'b0;
                break;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_stats();
        int writes;
        bit to;
        do_reset();
        writes          = 0;
        stat_sel        = 2'd2;
        req_data[23:16] = 8'h60;
        run_beats(10, writes, to);
        check_cnt++;
        if (to) $display("FAIL stats_timeout10: got %0d beats want 10", writes);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (stat_cnt !== CNT_W'(EXP_CNT10)) $display("FAIL stats_10: got %0d want %0d", stat_cnt, EXP_CNT10);
        else pass_cnt++;
        stat_sel = 2'd3;
        #1;
        check_cnt++;
        if (stat_cnt !== '0) $display("FAIL stats_sel3: got %0d want 0", stat_cnt);
        else pass_cnt++;
        stat_sel = 2'd2;
        tick();
        run_beats(30, writes, to);
        check_cnt++;
        if (to) $display("FAIL stats_timeout30: got %0d beats want 30", writes);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (stat_cnt !== CNT_W'(EXP_CNT30)) $display("FAIL stats_30: got %0d want %0d", stat_cnt, EXP_CNT30);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        stat_sel  = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_valid_drop();
        test_stats();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
